// File: rtl/freq_divider_prog.sv
// Programmable divider: CLOCK_50 -> 1/2/4/8 Hz 50%-duty clock plus a rising-edge tick.
// Latency: first toggle lands H = HALF_1HZ >> sel cycles after the RUN entry edge; outputs registered.
// Backpressure: none; run=0 freezes the divider mid-period. Optional step input under macro DIV_STEP_EN.
module freq_divider_prog #(
    parameter int HALF_1HZ   = 25_000_000,
    parameter int CNT_W      = 25
`ifdef DIV_STEP_EN
    ,
    parameter int DEB_CYCLES = 1_000_000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] sel,
`ifdef DIV_STEP_EN
    input  logic       step,
`endif
    output logic       clock,
    output logic       tick
);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half_len;
    logic             terminal;
    logic             clock_nxt;
    logic             tick_nxt;
    logic             load_sel;

    // Half-period length follows the latched rate, never the live switches.
    assign half_len = CNT_W'(HALF_1HZ >> sel_q);

    // ">=" rather than "==": a rate raised while paused can leave cnt beyond
    // the new limit; the divider then toggles on the first counting cycle
    // instead of wrapping through the whole counter range.
    assign terminal = (cnt >= (half_len - CNT_ONE));

`ifdef DIV_STEP_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    logic             step_meta;
    logic             step_sync;
    logic             step_deb;
    logic             step_deb_q;
    logic [DEB_W-1:0] deb_cnt;
    logic             step_press;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
        end
    end

    // Debounce: adopt the synchronized level only after DEB_CYCLES consecutive
    // cycles of disagreement; any return to the old level restarts the count.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            step_deb <= 1'b0;
            deb_cnt  <= '0;
        end else if (step_sync != step_deb) begin
            if (deb_cnt == DEB_LAST) begin
                step_deb <= step_sync;
                deb_cnt  <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_ONE;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            step_deb_q <= 1'b0;
        end else begin
            step_deb_q <= step_deb;
        end
    end

    assign step_press = step_deb & ~step_deb_q;
`endif

    // FSM state register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= PAUSE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus counter/clock/tick updates for the coming edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clock_nxt = clock;
        tick_nxt  = 1'b0;
        load_sel  = 1'b0;
        case (state)
            PAUSE: begin
                // Rate tracks the switches while frozen so a resume uses the new rate.
                load_sel = 1'b1;
                if (run) begin
                    state_nxt = RUN;
                end
`ifdef DIV_STEP_EN
                else if (step_press && !clock) begin
                    // Forced single period: rise now, fall after H cycles.
                    state_nxt = STEP;
                    cnt_nxt   = '0;
                    clock_nxt = 1'b1;
                    tick_nxt  = 1'b1;
                end
`endif
            end
            RUN: begin
                // run=0 wins over a terminal count: nothing moves on this edge.
                if (!run) begin
                    state_nxt = PAUSE;
                end else if (terminal) begin
                    cnt_nxt   = '0;
                    clock_nxt = ~clock;
                    tick_nxt  = ~clock;
                    load_sel  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
`ifdef DIV_STEP_EN
            STEP: begin
                // The step period always completes; run only picks the exit state.
                if (terminal) begin
                    cnt_nxt   = '0;
                    clock_nxt = 1'b0;
                    load_sel  = 1'b1;
                    state_nxt = run ? RUN : PAUSE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
`endif
            default: begin
                state_nxt = PAUSE;
            end
        endcase
    end

    // Counter, divided clock, tick and rate latch registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            clock <= 1'b0;
            tick  <= 1'b0;
            sel_q <= 2'b00;
        end else begin
            cnt   <= cnt_nxt;
            clock <= clock_nxt;
            tick  <= tick_nxt;
            if (load_sel) begin
                sel_q <= sel;
            end
        end
    end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Bench for freq_divider_prog with HALF_1HZ=8 and DEB_CYCLES=4.
// Directed scenarios check exact cycle counts; a random phase compares against a period-level model.
// Outputs sampled 1 ns after each rising edge; inputs changed at that point too.
module tb_freq_divider_prog;

    localparam int HALF = 8;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       run;
    logic [1:0] sel;
`ifdef DIV_STEP_EN
    logic       step;
`endif
    logic       clock;
    logic       tick;

    int checks = 0;
    int errors = 0;

    // Model: divider is "live" once run has been seen for an edge; it spends
    // h live edges per half-period, then flips level and picks up the new rate.
    logic m_live;
    logic m_level;
    logic m_tick;
    int   m_elapsed;
    int   m_h;

    freq_divider_prog #(
        .HALF_1HZ  (HALF),
        .CNT_W     (4)
`ifdef DIV_STEP_EN
        ,
        .DEB_CYCLES(4)
`endif
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .run     (run),
        .sel     (sel),
`ifdef DIV_STEP_EN
        .step    (step),
`endif
        .clock   (clock),
        .tick    (tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_live    = 1'b0;
        m_level   = 1'b0;
        m_tick    = 1'b0;
        m_elapsed = 0;
        m_h       = HALF;
    endtask

    task automatic model_edge();
        logic new_tick;
        new_tick = 1'b0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_live && run) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed >= m_h) begin
                m_level   = ~m_level;
                new_tick  = m_level;
                m_elapsed = 0;
                m_h       = HALF >> sel;
            end
        end
        if (!m_live) m_h = HALF >> sel;
        m_live = run;
        m_tick = new_tick;
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    // Edges until tick is seen; -1 when the budget runs out.
    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Edges until the divided clock shows lvl; -1 when the budget runs out.
    task automatic wait_level(input logic lvl, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (clock === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        run   = 1'b0;
        sel   = 2'b00;
`ifdef DIV_STEP_EN
        step  = 1'b0;
`endif
        model_reset();
        #12;
        checks++;
        if (clock !== 1'b0) begin errors++; $display("FAIL reset_clock: got %b expected 0", clock); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        cyc();
        reset = 1'b0;
        run   = 1'b1;
        wait_level(1'b1, 40, n);
        checks++;
        if (n < 0) begin errors++; $display("FAIL reset_prep_rise: got %0d expected >0", n); end
        cyc(); cyc(); cyc();
        // Asynchronous reset in the middle of a high half-period.
        #3 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (clock !== 1'b0) begin errors++; $display("FAIL reset_async_clock: got %b expected 0", clock); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_async_tick: got %b expected 0", tick); end
        cyc();
        reset = 1'b0;
        // First edge is the RUN entry edge, then H more to the first tick.
        wait_tick(40, n);
        checks++;
        if (n != HALF + 1) begin errors++; $display("FAIL first_tick_latency: got %0d expected %0d", n, HALF + 1); end
        wait_level(1'b0, 40, n);
        checks++;
        if (n != HALF) begin errors++; $display("FAIL high_width: got %0d expected %0d", n, HALF); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL tick_on_fall: got %b expected 0", tick); end
        wait_tick(40, n);
        checks++;
        if (n != HALF) begin errors++; $display("FAIL low_width: got %0d expected %0d", n, HALF); end
        cyc();
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL tick_width: got %b expected 0", tick); end
        wait_tick(40, n);
        checks++;
        if (n != 2 * HALF - 1) begin errors++; $display("FAIL tick_period: got %0d expected %0d", n + 1, 2 * HALF); end
    endtask

    task automatic test_sel_change();
        int n;
        // Just after a tick: cnt=0. Three edges bring cnt to 3.
        cyc(); cyc(); cyc();
        sel = 2'b11;
        wait_level(1'b0, 40, n);
        checks++;
        if (n != HALF - 3) begin errors++; $display("FAIL sel_old_half: got %0d expected %0d", n, HALF - 3); end
        wait_tick(10, n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL sel_fast_first: got %0d expected 1", n); end
        wait_tick(10, n);
        checks++;
        if (n != 2) begin errors++; $display("FAIL sel_fast_period_a: got %0d expected 2", n); end
        cyc();
        checks++;
        if (clock !== 1'b0) begin errors++; $display("FAIL sel_fast_low: got %b expected 0", clock); end
        wait_tick(10, n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL sel_fast_period_b: got %0d expected 1", n); end
        sel = 2'b00;
        // Next edge falls and reloads 1 Hz; the following rise is H later.
        wait_tick(40, n);
        checks++;
        if (n != HALF + 1) begin errors++; $display("FAIL sel_back_slow: got %0d expected %0d", n, HALF + 1); end
    endtask

    task automatic test_pause_mid();
        int n;
        int bad;
        cyc(); cyc(); cyc(); cyc(); cyc();
        run = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (clock !== 1'b1 || tick !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
        run = 1'b1;
        // Entry edge, then cnt 5->6->7, then the fall: 3 counting cycles after entry.
        wait_level(1'b0, 20, n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL pause_resume_fall: got %0d expected 4", n); end
    endtask

    task automatic test_pause_terminal();
        int n;
        // Just after a fall: cnt=0, clock=0. Seven edges bring cnt to H-1.
        for (int i = 0; i < HALF - 1; i++) cyc();
        run = 1'b0;
        cyc();
        checks++;
        if (clock !== 1'b0) begin errors++; $display("FAIL term_no_toggle: got %b expected 0", clock); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL term_no_tick: got %b expected 0", tick); end
        cyc(); cyc(); cyc();
        run = 1'b1;
        cyc();
        checks++;
        if (clock !== 1'b0) begin errors++; $display("FAIL term_entry_hold: got %b expected 0", clock); end
        cyc();
        checks++;
        if (tick !== 1'b1 || clock !== 1'b1) begin
            errors++; $display("FAIL term_resume_tick: got tick=%b clock=%b expected 1 1", tick, clock);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) run = ~run;
            if ($urandom_range(19) == 0) sel = 2'($urandom_range(3));
            cyc();
            checks++;
            if (clock !== m_level) begin errors++; $display("FAIL rand_clock cycle %0d: got %b expected %b", i, clock, m_level); end
            checks++;
            if (tick !== m_tick) begin errors++; $display("FAIL rand_tick cycle %0d: got %b expected %b", i, tick, m_tick); end
        end
    endtask

`ifdef DIV_STEP_EN
    task automatic test_step_pause();
        int ticks;
        int hi;
        reset = 1'b1;
        run   = 1'b0;
        sel   = 2'b00;
        step  = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc(); cyc();
        ticks = 0;
        hi    = 0;
        step  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i == 6) step = 1'b0;
            cyc();
            if (tick === 1'b1) ticks++;
            if (clock === 1'b1) hi++;
        end
        checks++;
        if (ticks != 1) begin errors++; $display("FAIL step_tick_count: got %0d expected 1", ticks); end
        checks++;
        if (hi != HALF) begin errors++; $display("FAIL step_high_cycles: got %0d expected %0d", hi, HALF); end
        checks++;
        if (clock !== 1'b0) begin errors++; $display("FAIL step_back_low: got %b expected 0", clock); end
        ticks = 0;
        hi    = 0;
        for (int r = 0; r < 4; r++) begin
            step = 1'b1;
            cyc(); if (tick === 1'b1) ticks++; if (clock === 1'b1) hi++;
            cyc(); if (tick === 1'b1) ticks++; if (clock === 1'b1) hi++;
            step = 1'b0;
            cyc(); if (tick === 1'b1) ticks++; if (clock === 1'b1) hi++;
            cyc(); if (tick === 1'b1) ticks++; if (clock === 1'b1) hi++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tick === 1'b1) ticks++;
            if (clock === 1'b1) hi++;
        end
        checks++;
        if (ticks != 0) begin errors++; $display("FAIL bounce_ticks: got %0d expected 0", ticks); end
        checks++;
        if (hi != 0) begin errors++; $display("FAIL bounce_clock_high: got %0d expected 0", hi); end
    endtask

    task automatic test_step_run();
        int n;
        reset = 1'b1;
        run   = 1'b1;
        sel   = 2'b00;
        step  = 1'b0;
        cyc();
        reset = 1'b0;
        wait_tick(40, n);
        checks++;
        if (n != HALF + 1) begin errors++; $display("FAIL step_run_first: got %0d expected %0d", n, HALF + 1); end
        step = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 7) step = 1'b0;
            cyc();
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 2 * HALF) begin errors++; $display("FAIL step_run_period_a: got %0d expected %0d", n, 2 * HALF); end
        wait_tick(40, n);
        checks++;
        if (n != 2 * HALF) begin errors++; $display("FAIL step_run_period_b: got %0d expected %0d", n, 2 * HALF); end
    endtask
`endif

    initial begin
        test_reset();
        test_sel_change();
        test_pause_mid();
        test_pause_terminal();
        test_random();
`ifdef DIV_STEP_EN
        test_step_pause();
        test_step_run();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
